// File: rtl/pipeline_ctrl_pkg.sv
// Shared stage indexing, FSM state encoding and stage-mask helper for the pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ST_* stage indices (IF=0 .. WB=6), STAGES, state_t, stage_mask().
package pipeline_ctrl_pkg;

  localparam int STAGES  = 7;
  localparam int ST_IF   = 0;
  localparam int ST_ID   = 1;
  localparam int ST_EXA  = 2;
  localparam int ST_EXB  = 3;
  localparam int ST_MEMP = 4;
  localparam int ST_MEMR = 5;
  localparam int ST_WB   = 6;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LD_STALL    = 2'd1,
    MEM_WAIT    = 2'd2,
    MEM_WAIT_BR = 2'd3
  } state_t;

  // Contiguous run of stage bits lo..hi inclusive.
  function automatic logic [STAGES-1:0] stage_mask(input int lo, input int hi);
    logic [STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i >= lo && i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Latency: value reflects inc one clock after it is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc (count this cycle), value (current count).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 7-stage pipeline: memory wait, branch redirect, load-use stall.
// Latency: stall/flush/redirect/timeout are combinational (zero cycle); FSM and counters registered.
// Backpressure: a data-memory wait freezes IF..MEMP and bubbles MEMR; forced release after MEM_TIMEOUT cycles.
// Ports: hazard inputs (no_forwarding_data, branch_*_EXB, mem_req_MEMP, mem_ready);
//        per-stage stall_o/flush_o, redirect_valid_o/redirect_pc_o, mem_timeout_o, perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int PC_W        = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              no_forwarding_data,
  input  logic              branch_taken_EXB,
  input  logic [PC_W-1:0]   branch_target_EXB,
  input  logic              mem_req_MEMP,
  input  logic              mem_ready,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] flush_o,
  output logic              redirect_valid_o,
  output logic [PC_W-1:0]   redirect_pc_o,
  output logic              mem_timeout_o,
  output logic [31:0]       stall_cycles_o,
  output logic [15:0]       redirect_count_o
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam int CNT_W = (TMO_W > 8) ? TMO_W : 8;

  localparam logic [STAGES-1:0] M_ALL        = stage_mask(ST_IF, ST_WB);
  localparam logic [STAGES-1:0] M_WAIT_STALL = stage_mask(ST_IF, ST_MEMP);
  localparam logic [STAGES-1:0] M_WAIT_FLUSH = stage_mask(ST_MEMR, ST_MEMR);
  localparam logic [STAGES-1:0] M_TMO_FLUSH  = stage_mask(ST_MEMP, ST_MEMP);
  // Everything younger than the resolving stage is on the wrong path.
  localparam logic [STAGES-1:0] M_REDIR      = stage_mask(ST_IF, ST_EXB - 1);
  localparam logic [STAGES-1:0] M_LU_STALL   = stage_mask(ST_IF, ST_ID);
  localparam logic [STAGES-1:0] M_LU_FLUSH   = stage_mask(ST_EXA, ST_EXA);

  state_t            state_q, state_n;
  logic [PC_W-1:0]   tgt_q, tgt_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;

  logic wait_c;
  logic pending;
  logic in_wait;
  logic timeout;

  assign wait_c  = mem_req_MEMP & ~mem_ready;
  // The pending-branch flag is carried by the state encoding itself.
  assign pending = (state_q == MEM_WAIT_BR);
  assign in_wait = (state_q == MEM_WAIT) || pending;
  assign timeout = wait_c && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    stall_o          = '0;
    flush_o          = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    mem_timeout_o    = 1'b0;
    state_n          = state_q;
    tgt_n            = tgt_q;
    cnt_n            = cnt_q;

    if (!rst_n) begin
      flush_o = M_ALL;
      state_n = RUN;
      tgt_n   = '0;
      cnt_n   = '0;
    end else if (timeout) begin
      // Forced release: drop the stuck MEMP request, still honour a pending branch.
      mem_timeout_o = 1'b1;
      flush_o       = M_TMO_FLUSH;
      if (pending || branch_taken_EXB) begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = branch_taken_EXB ? branch_target_EXB : tgt_q;
        flush_o          = flush_o | M_REDIR;
      end
      state_n = RUN;
      tgt_n   = '0;
      cnt_n   = '0;
    end else if (wait_c) begin
      stall_o = M_WAIT_STALL;
      flush_o = M_WAIT_FLUSH;
      cnt_n   = cnt_q + CNT_W'(1);
      // A branch resolving while frozen is parked and replayed at release.
      if (branch_taken_EXB) tgt_n = branch_target_EXB;
      state_n = (branch_taken_EXB || pending) ? MEM_WAIT_BR : MEM_WAIT;
    end else if (in_wait) begin
      if (pending || branch_taken_EXB) begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = branch_taken_EXB ? branch_target_EXB : tgt_q;
        flush_o          = M_REDIR;
      end
      state_n = RUN;
      tgt_n   = '0;
      cnt_n   = '0;
    end else if (branch_taken_EXB) begin
      // Load-use on a wrong-path instruction is irrelevant; it is being flushed.
      redirect_valid_o = 1'b1;
      redirect_pc_o    = branch_target_EXB;
      flush_o          = M_REDIR;
      state_n          = RUN;
    end else if (no_forwarding_data) begin
      stall_o = M_LU_STALL;
      flush_o = M_LU_FLUSH;
      state_n = LD_STALL;
    end else begin
      state_n = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      tgt_q   <= tgt_n;
      cnt_q   <= cnt_n;
    end
  end

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (|stall_o),
    .value (stall_cycles_o)
  );

  sat_counter #(.WIDTH(16)) u_redir_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_valid_o),
    .value (redirect_count_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, timeout sequences, random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        no_forwarding_data;
  logic        branch_taken_EXB;
  logic [63:0] branch_target_EXB;
  logic        mem_req_MEMP;
  logic        mem_ready;

  logic [6:0]  stall_a, flush_a, stall_b, flush_b;
  logic        rv_a, rv_b, tmo_a, tmo_b;
  logic [63:0] pc_a, pc_b;
  logic [31:0] stc_a, stc_b;
  logic [15:0] rdc_a, rdc_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .no_forwarding_data (no_forwarding_data),
    .branch_taken_EXB   (branch_taken_EXB),
    .branch_target_EXB  (branch_target_EXB),
    .mem_req_MEMP       (mem_req_MEMP),
    .mem_ready          (mem_ready),
    .stall_o            (stall_a),
    .flush_o            (flush_a),
    .redirect_valid_o   (rv_a),
    .redirect_pc_o      (pc_a),
    .mem_timeout_o      (tmo_a),
    .stall_cycles_o     (stc_a),
    .redirect_count_o   (rdc_a)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut_t (
    .clk                (clk),
    .rst_n              (rst_n),
    .no_forwarding_data (no_forwarding_data),
    .branch_taken_EXB   (branch_taken_EXB),
    .branch_target_EXB  (branch_target_EXB),
    .mem_req_MEMP       (mem_req_MEMP),
    .mem_ready          (mem_ready),
    .stall_o            (stall_b),
    .flush_o            (flush_b),
    .redirect_valid_o   (rv_b),
    .redirect_pc_o      (pc_b),
    .mem_timeout_o      (tmo_b),
    .stall_cycles_o     (stc_b),
    .redirect_count_o   (rdc_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one set of abstract state per instance (0: timeout 255, 1: timeout 4).
  int          tmo_lim[2] = '{255, 4};
  bit          m_wait[2];
  bit          m_pend[2];
  logic [63:0] m_tgt[2];
  int          m_cnt[2];
  longint      m_stc[2];
  int          m_rdc[2];

  task automatic model_check(input int k);
    logic [6:0]  es, ef, as_, af;
    logic        erv, etmo, arv, atmo;
    logic [63:0] epc, apc;
    logic [31:0] astc;
    logic [15:0] ardc;
    bit          w, nwait, npend;
    logic [63:0] ntgt;
    int          ncnt;
    as_  = (k == 0) ? stall_a : stall_b;
    af   = (k == 0) ? flush_a : flush_b;
    arv  = (k == 0) ? rv_a    : rv_b;
    apc  = (k == 0) ? pc_a    : pc_b;
    atmo = (k == 0) ? tmo_a   : tmo_b;
    astc = (k == 0) ? stc_a   : stc_b;
    ardc = (k == 0) ? rdc_a   : rdc_b;
    es = '0; ef = '0; erv = 1'b0; epc = '0; etmo = 1'b0;
    w = mem_req_MEMP && !mem_ready;
    nwait = m_wait[k]; npend = m_pend[k]; ntgt = m_tgt[k]; ncnt = m_cnt[k];
    if (!rst_n) begin
      ef = 7'h7F;
      nwait = 0; npend = 0; ntgt = '0; ncnt = 0;
      m_stc[k] = 0; m_rdc[k] = 0;
    end else if (w && m_cnt[k] == tmo_lim[k] - 1) begin
      etmo = 1'b1;
      ef   = 7'h10;
      if (m_pend[k] || branch_taken_EXB) begin
        erv = 1'b1;
        epc = branch_taken_EXB ? branch_target_EXB : m_tgt[k];
        ef  = 7'h17;
      end
      nwait = 0; npend = 0; ncnt = 0;
    end else if (w) begin
      es = 7'h1F; ef = 7'h20;
      if (branch_taken_EXB) begin npend = 1; ntgt = branch_target_EXB; end
      nwait = 1; ncnt = m_cnt[k] + 1;
    end else if (m_wait[k]) begin
      if (m_pend[k] || branch_taken_EXB) begin
        erv = 1'b1;
        epc = branch_taken_EXB ? branch_target_EXB : m_tgt[k];
        ef  = 7'h07;
      end
      nwait = 0; npend = 0; ncnt = 0;
    end else if (branch_taken_EXB) begin
      erv = 1'b1; epc = branch_target_EXB; ef = 7'h07;
    end else if (no_forwarding_data) begin
      es = 7'h03; ef = 7'h04;
    end
    chk($sformatf("m%0d.stall", k), 64'(as_), 64'(es));
    chk($sformatf("m%0d.flush", k), 64'(af), 64'(ef));
    chk($sformatf("m%0d.redir_vld", k), 64'(arv), 64'(erv));
    chk($sformatf("m%0d.redir_pc", k), apc, epc);
    chk($sformatf("m%0d.timeout", k), 64'(atmo), 64'(etmo));
    chk($sformatf("m%0d.stall_cnt", k), 64'(astc), 64'(m_stc[k]));
    chk($sformatf("m%0d.redir_cnt", k), 64'(ardc), 64'(m_rdc[k]));
    if (es != 0 && m_stc[k] < 64'hFFFF_FFFF) m_stc[k]++;
    if (erv && m_rdc[k] < 65535) m_rdc[k]++;
    m_wait[k] = nwait; m_pend[k] = npend; m_tgt[k] = ntgt; m_cnt[k] = ncnt;
  endtask

  task automatic drive(input bit r, input bit n, input bit b, input logic [63:0] t,
                       input bit q, input bit y);
    rst_n              = r;
    no_forwarding_data = n;
    branch_taken_EXB   = b;
    branch_target_EXB  = t;
    mem_req_MEMP       = q;
    mem_ready          = y;
  endtask

  // Check point sits on the falling edge; inputs change 1 time unit after the rising edge.
  task automatic step_begin();
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic step_end();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst, nf, br;
    logic [63:0] tgt;
    bit          req, rdy;
    logic [6:0]  stall, flush;
    bit          rv;
    logic [63:0] pc;
    bit          tmo;
    int          stc, rdc;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit nf, input bit br, input logic [63:0] tgt,
                              input bit req, input bit rdy, input logic [6:0] stall,
                              input logic [6:0] flush, input bit rv, input logic [63:0] pc,
                              input bit tmo, input int stc, input int rdc);
    vec_t v;
    v.rst = rst; v.nf = nf; v.br = br; v.tgt = tgt; v.req = req; v.rdy = rdy;
    v.stall = stall; v.flush = flush; v.rv = rv; v.pc = pc; v.tmo = tmo;
    v.stc = stc; v.rdc = rdc;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    //                rst nf br tgt                      req rdy stall  flush  rv pc                       tmo stc rdc
    vecs.push_back(mk(0, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h7F, 0, 64'h0,                    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 0, 0));
    // memory wait of 3 cycles then ready
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 2, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 1, 7'h00, 7'h00, 0, 64'h0,                    0, 3, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 3, 0));
    // load-use for 2 cycles
    vecs.push_back(mk(1, 1, 0, 64'h0,                    0, 0, 7'h03, 7'h04, 0, 64'h0,                    0, 3, 0));
    vecs.push_back(mk(1, 1, 0, 64'h0,                    0, 0, 7'h03, 7'h04, 0, 64'h0,                    0, 4, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 5, 0));
    // 4-cycle wait with a branch in wait cycle 2
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 5, 0));
    vecs.push_back(mk(1, 0, 1, 64'h8000_0040,            1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 6, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 7, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 8, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 1, 7'h00, 7'h07, 1, 64'h8000_0040,            0, 9, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 9, 1));
    // branch and load-use together, no wait
    vecs.push_back(mk(1, 1, 1, 64'h1234_5678_9ABC_DEF0,  0, 0, 7'h00, 7'h07, 1, 64'h1234_5678_9ABC_DEF0,  0, 9, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 9, 2));
    // reset during a wait with a pending branch
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 9, 2));
    vecs.push_back(mk(1, 0, 1, 64'hDEAD_0000,            1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 10, 2));
    vecs.push_back(mk(0, 0, 0, 64'h0,                    1, 0, 7'h00, 7'h7F, 0, 64'h0,                    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 1, 7'h00, 7'h00, 0, 64'h0,                    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 0, 0));
    // plain branch, then a request that is ready at once
    vecs.push_back(mk(1, 0, 1, 64'h40,                   0, 0, 7'h00, 7'h07, 1, 64'h40,                   0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 1, 7'h00, 7'h00, 0, 64'h0,                    0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 0, 1));
    // wait beats load-use; release cycle ignores the hazard
    vecs.push_back(mk(1, 1, 0, 64'h0,                    1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 64'h0,                    1, 1, 7'h00, 7'h00, 0, 64'h0,                    0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 64'h0,                    0, 0, 7'h03, 7'h04, 0, 64'h0,                    0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 2, 1));
    // branch on the very first wait cycle
    vecs.push_back(mk(1, 0, 1, 64'h77,                   1, 0, 7'h1F, 7'h20, 0, 64'h0,                    0, 2, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    1, 1, 7'h00, 7'h07, 1, 64'h77,                   0, 3, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,                    0, 0, 7'h00, 7'h00, 0, 64'h0,                    0, 3, 2));

    drive(0, 0, 0, 64'h0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].nf, vecs[i].br, vecs[i].tgt, vecs[i].req, vecs[i].rdy);
      step_begin();
      chk($sformatf("v%0d.stall", i), 64'(stall_a), 64'(vecs[i].stall));
      chk($sformatf("v%0d.flush", i), 64'(flush_a), 64'(vecs[i].flush));
      chk($sformatf("v%0d.redir_vld", i), 64'(rv_a), 64'(vecs[i].rv));
      chk($sformatf("v%0d.redir_pc", i), pc_a, vecs[i].pc);
      chk($sformatf("v%0d.timeout", i), 64'(tmo_a), 64'(vecs[i].tmo));
      chk($sformatf("v%0d.stall_cnt", i), 64'(stc_a), 64'(vecs[i].stc));
      chk($sformatf("v%0d.redir_cnt", i), 64'(rdc_a), 64'(vecs[i].rdc));
      step_end();
    end

    // Timeout with a 4-cycle limit: branch parked in wait cycle 2, forced release on cycle 4.
    drive(0, 0, 0, 64'h0, 0, 0); step_begin(); step_end();
    drive(1, 0, 0, 64'h0, 0, 0); step_begin(); step_end();
    drive(1, 0, 0, 64'h0, 1, 0); step_begin();
    chk("to.c1.stall", 64'(stall_b), 64'h1F);
    step_end();
    drive(1, 0, 1, 64'hCAFE_F00D, 1, 0); step_begin();
    chk("to.c2.redir_vld", 64'(rv_b), 64'h0);
    step_end();
    drive(1, 0, 0, 64'h0, 1, 0); step_begin();
    chk("to.c3.timeout", 64'(tmo_b), 64'h0);
    step_end();
    step_begin();
    chk("to.c4.timeout", 64'(tmo_b), 64'h1);
    chk("to.c4.stall", 64'(stall_b), 64'h00);
    chk("to.c4.flush", 64'(flush_b), 64'h17);
    chk("to.c4.redir_vld", 64'(rv_b), 64'h1);
    chk("to.c4.redir_pc", pc_b, 64'hCAFE_F00D);
    chk("to.c4.long_limit_stall", 64'(stall_a), 64'h1F);
    step_end();
    // Still not ready: a fresh wait runs, then a plain forced release.
    for (int c = 5; c <= 7; c++) begin
      step_begin();
      chk($sformatf("to.c%0d.stall", c), 64'(stall_b), 64'h1F);
      step_end();
    end
    step_begin();
    chk("to.c8.timeout", 64'(tmo_b), 64'h1);
    chk("to.c8.stall", 64'(stall_b), 64'h00);
    chk("to.c8.flush", 64'(flush_b), 64'h10);
    chk("to.c8.redir_vld", 64'(rv_b), 64'h0);
    step_end();
    drive(1, 0, 0, 64'h0, 0, 0); step_begin();
    chk("to.c9.timeout", 64'(tmo_b), 64'h0);
    chk("to.c9.redir_cnt", 64'(rdc_b), 64'h1);
    step_end();

    // Random traffic, both instances checked against the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 199) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            {$urandom, $urandom},
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0);
      step_begin();
      step_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
